// File: rtl/tick_generator.sv
// Configurable timebase: divides tick_clock into a one-cycle tick with run/hold,
// synchronous clear, fast-forward mode, a mid-period tick and a 50 % blink.
module tick_generator #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int TICK_HZ   = 1,
    parameter int FAST_MULT = 100,
    parameter int W         = $clog2(CLK_HZ / TICK_HZ)
) (
    input  logic         tick_clock,
    input  logic         tick_reset_n,
    input  logic         tick_run,
    input  logic         tick_clear,
    input  logic         tick_fast,
    output logic         tick_pulse,
    output logic         tick_half,
    output logic         tick_blink,
    output logic [W-1:0] tick_phase
);

    localparam int DIV      = CLK_HZ / TICK_HZ;
    localparam int DIV_FAST = DIV / FAST_MULT;

    if ((DIV % 2) != 0 || DIV < 4) begin : g_bad_div
        $error("tick_generator: DIV must be even and at least 4");
    end
    if ((DIV % FAST_MULT) != 0) begin : g_bad_mult
        $error("tick_generator: DIV must be a multiple of FAST_MULT");
    end
    if ((DIV_FAST % 2) != 0 || DIV_FAST < 2) begin : g_bad_fast
        $error("tick_generator: DIV_FAST must be even and at least 2");
    end

    localparam logic [W-1:0] SLOW_LAST = W'(DIV - 1);
    localparam logic [W-1:0] SLOW_MID  = W'(DIV / 2 - 1);
    localparam logic [W-1:0] FAST_LAST = W'(DIV_FAST - 1);
    localparam logic [W-1:0] FAST_MID  = W'(DIV_FAST / 2 - 1);

    logic [W-1:0] phase_q, phase_d;
    logic         pulse_q, pulse_d;
    logic         half_q, half_d;
    logic         blink_q, blink_d;
    logic         fast_q;
    logic [W-1:0] last_phase;
    logic [W-1:0] mid_phase;
    logic         mode_change;

    // Outside a mode change tick_fast equals fast_q, so the registered copy
    // can select the limits without putting the input on the compare path.
    assign last_phase  = fast_q ? FAST_LAST : SLOW_LAST;
    assign mid_phase   = fast_q ? FAST_MID  : SLOW_MID;
    assign mode_change = (tick_fast != fast_q);

    always_comb begin
        phase_d = phase_q;
        blink_d = blink_q;
        pulse_d = 1'b0;
        half_d  = 1'b0;
        if (tick_clear || mode_change) begin
            phase_d = '0;
            blink_d = 1'b0;
        end else if (tick_run) begin
            if (phase_q == last_phase) begin
                phase_d = '0;
                pulse_d = 1'b1;
                blink_d = 1'b0;
            end else begin
                phase_d = phase_q + W'(1);
                if (phase_q == mid_phase) begin
                    half_d  = 1'b1;
                    blink_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge tick_clock or negedge tick_reset_n) begin
        if (!tick_reset_n) begin
            phase_q <= '0;
            pulse_q <= 1'b0;
            half_q  <= 1'b0;
            blink_q <= 1'b0;
            fast_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            pulse_q <= pulse_d;
            half_q  <= half_d;
            blink_q <= blink_d;
            fast_q  <= tick_fast;
        end
    end

    assign tick_phase = phase_q;
    assign tick_pulse = pulse_q;
    assign tick_half  = half_q;
    assign tick_blink = blink_q;

endmodule

// File: tb/tb_tick_generator.sv
// Directed bench for tick_generator with DIV = 20 and DIV_FAST = 4.
module tb_tick_generator;

    localparam int CLK_HZ    = 20;
    localparam int TICK_HZ   = 1;
    localparam int FAST_MULT = 5;
    localparam int W         = 5;

    logic         tick_clock = 1'b0;
    logic         tick_reset_n = 1'b0;
    logic         tick_run = 1'b0;
    logic         tick_clear = 1'b0;
    logic         tick_fast = 1'b0;
    logic         tick_pulse;
    logic         tick_half;
    logic         tick_blink;
    logic [W-1:0] tick_phase;

    int tests_run = 0;
    int tests_failed = 0;

    tick_generator #(
        .CLK_HZ   (CLK_HZ),
        .TICK_HZ  (TICK_HZ),
        .FAST_MULT(FAST_MULT)
    ) dut (
        .tick_clock  (tick_clock),
        .tick_reset_n(tick_reset_n),
        .tick_run    (tick_run),
        .tick_clear  (tick_clear),
        .tick_fast   (tick_fast),
        .tick_pulse  (tick_pulse),
        .tick_half   (tick_half),
        .tick_blink  (tick_blink),
        .tick_phase  (tick_phase)
    );

    always #5 tick_clock = ~tick_clock;

    // Packed view {phase, pulse, half, blink}, printed as hex in FAIL lines.
    function automatic logic [W+2:0] observed();
        return {tick_phase, tick_pulse, tick_half, tick_blink};
    endfunction

    function automatic logic [W+2:0] exp_vec(int p, bit pulse, bit half, bit blink);
        return {W'(p), pulse, half, blink};
    endfunction

    task automatic step();
        @(posedge tick_clock);
        #1;
    endtask

    task automatic apply_reset();
        tick_reset_n = 1'b0;
        tick_run     = 1'b0;
        tick_clear   = 1'b0;
        tick_fast    = 1'b0;
        repeat (2) step();
        tick_reset_n = 1'b1;
    endtask

    task automatic run_edges(int n);
        tick_run = 1'b1;
        repeat (n) step();
    endtask

    task automatic test_reset();
        tick_reset_n = 1'b0;
        tick_run     = 1'b1;
        tick_fast    = 1'b0;
        tick_clear   = 1'b0;
        #1;
        tests_run++;
        if (observed() !== exp_vec(0, 0, 0, 0)) begin
            tests_failed++;
            $display("[TB] FAIL reset_initial: got %h want %h", observed(), exp_vec(0, 0, 0, 0));
        end
        step();
        tests_run++;
        if (observed() !== exp_vec(0, 0, 0, 0)) begin
            tests_failed++;
            $display("[TB] FAIL reset_held_edge: got %h want %h", observed(), exp_vec(0, 0, 0, 0));
        end
    endtask

    task automatic test_free_run();
        int p;
        apply_reset();
        tick_run = 1'b1;
        for (int e = 1; e <= 62; e++) begin
            step();
            p = e % 20;
            tests_run++;
            if (observed() !== exp_vec(p, p == 0, p == 10, p >= 10)) begin
                tests_failed++;
                $display("[TB] FAIL free_run edge %0d: got %h want %h", e, observed(),
                         exp_vec(p, p == 0, p == 10, p >= 10));
            end
        end
    endtask

    task automatic test_hold();
        int p;
        apply_reset();
        run_edges(7);
        tick_run = 1'b0;
        for (int n = 1; n <= 15; n++) begin
            step();
            tests_run++;
            if (observed() !== exp_vec(7, 0, 0, 0)) begin
                tests_failed++;
                $display("[TB] FAIL hold edge %0d: got %h want %h", n, observed(), exp_vec(7, 0, 0, 0));
            end
        end
        tick_run = 1'b1;
        for (int n = 1; n <= 13; n++) begin
            step();
            p = (7 + n) % 20;
            tests_run++;
            if (observed() !== exp_vec(p, n == 13, n == 3, p >= 10)) begin
                tests_failed++;
                $display("[TB] FAIL hold_resume edge %0d: got %h want %h", n, observed(),
                         exp_vec(p, n == 13, n == 3, p >= 10));
            end
        end
    endtask

    task automatic clear_and_follow(string name, bit run_during_clear);
        int p;
        apply_reset();
        run_edges(15);
        tick_run   = run_during_clear;
        tick_clear = 1'b1;
        step();
        tick_clear = 1'b0;
        tests_run++;
        if (observed() !== exp_vec(0, 0, 0, 0)) begin
            tests_failed++;
            $display("[TB] FAIL %s edge: got %h want %h", name, observed(), exp_vec(0, 0, 0, 0));
        end
        tick_run = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            step();
            p = n % 20;
            tests_run++;
            if (observed() !== exp_vec(p, n == 20, n == 10, p >= 10)) begin
                tests_failed++;
                $display("[TB] FAIL %s_follow edge %0d: got %h want %h", name, n, observed(),
                         exp_vec(p, n == 20, n == 10, p >= 10));
            end
        end
    endtask

    task automatic test_clear();
        clear_and_follow("clear_run", 1'b1);
        clear_and_follow("clear_hold", 1'b0);
    endtask

    task automatic test_fast();
        int p;
        apply_reset();
        tick_fast = 1'b1;
        step();
        tests_run++;
        if (observed() !== exp_vec(0, 0, 0, 0)) begin
            tests_failed++;
            $display("[TB] FAIL fast_enter: got %h want %h", observed(), exp_vec(0, 0, 0, 0));
        end
        tick_run = 1'b1;
        for (int n = 1; n <= 11; n++) begin
            step();
            p = n % 4;
            tests_run++;
            if (observed() !== exp_vec(p, p == 0, p == 2, p >= 2)) begin
                tests_failed++;
                $display("[TB] FAIL fast edge %0d: got %h want %h", n, observed(),
                         exp_vec(p, p == 0, p == 2, p >= 2));
            end
        end
        tick_fast = 1'b0;
        step();
        tests_run++;
        if (observed() !== exp_vec(0, 0, 0, 0)) begin
            tests_failed++;
            $display("[TB] FAIL fast_exit: got %h want %h", observed(), exp_vec(0, 0, 0, 0));
        end
        for (int n = 1; n <= 20; n++) begin
            step();
            p = n % 20;
            tests_run++;
            if (observed() !== exp_vec(p, n == 20, n == 10, p >= 10)) begin
                tests_failed++;
                $display("[TB] FAIL fast_exit_follow edge %0d: got %h want %h", n, observed(),
                         exp_vec(p, n == 20, n == 10, p >= 10));
            end
        end
    endtask

    task automatic test_async_reset();
        int p;
        apply_reset();
        run_edges(14);
        #2;
        tick_reset_n = 1'b0;
        #1;
        tests_run++;
        if (observed() !== exp_vec(0, 0, 0, 0)) begin
            tests_failed++;
            $display("[TB] FAIL async_reset: got %h want %h", observed(), exp_vec(0, 0, 0, 0));
        end
        step();
        tick_reset_n = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            step();
            p = n % 20;
            tests_run++;
            if (observed() !== exp_vec(p, n == 20, n == 10, p >= 10)) begin
                tests_failed++;
                $display("[TB] FAIL async_reset_follow edge %0d: got %h want %h", n, observed(),
                         exp_vec(p, n == 20, n == 10, p >= 10));
            end
        end
    endtask

    task automatic test_back_to_back();
        int p;
        apply_reset();
        run_edges(19);
        tests_run++;
        if (observed() !== exp_vec(19, 0, 0, 1)) begin
            tests_failed++;
            $display("[TB] FAIL simul_setup: got %h want %h", observed(), exp_vec(19, 0, 0, 1));
        end
        tick_clear = 1'b1;
        tick_fast  = 1'b1;
        step();
        tick_clear = 1'b0;
        tests_run++;
        if (observed() !== exp_vec(0, 0, 0, 0)) begin
            tests_failed++;
            $display("[TB] FAIL simul_edge: got %h want %h", observed(), exp_vec(0, 0, 0, 0));
        end
        for (int n = 1; n <= 8; n++) begin
            step();
            p = n % 4;
            tests_run++;
            if (observed() !== exp_vec(p, p == 0, p == 2, p >= 2)) begin
                tests_failed++;
                $display("[TB] FAIL simul_follow edge %0d: got %h want %h", n, observed(),
                         exp_vec(p, p == 0, p == 2, p >= 2));
            end
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_hold();
        test_clear();
        test_fast();
        test_async_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
